// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing and frame constants.
package uart_pkg;

  localparam int   CLKS_PER_BIT_DEFAULT = 217;  // 25 MHz / 115200 baud
  localparam int   DATA_BITS            = 8;
  localparam logic IDLE_LEVEL           = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_CLEANUP   = 3'd5,
    S_WAIT_IDLE = 3'd6
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous level input; both flops reset to the line idle level.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic i_Clock,
  input  logic i_Rst_L,
  input  logic i_Async,
  output logic o_Sync
);

  logic r_Meta;

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Meta <= IDLE_LEVEL;
      o_Sync <= IDLE_LEVEL;
    end else begin
      r_Meta <= i_Async;
      o_Sync <= r_Meta;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 with a live parity error strobe.
// o_RX_State exposes the FSM state for debug and checker binding.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic        i_Clock,
  input  logic        i_Rst_L,
  input  logic        i_RX_Serial,
  output logic        o_RX_DV,
  output logic [7:0]  o_RX_Byte,
  output logic        o_RX_Active,
  output logic        o_RX_Frame_Err,
  output logic        o_RX_Parity_Err,
  output uart_state_e o_RX_State
);

  localparam int             CW       = $clog2(CLKS_PER_BIT);
  localparam int             IW       = $clog2(DATA_BITS);
  localparam logic [CW-1:0]  HALF     = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0]  LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0]  LAST_IDX = IW'(DATA_BITS - 1);

  logic                 r_RX;
  uart_state_e          r_State, w_State;
  logic [CW-1:0]        r_Count, w_Count;
  logic [IW-1:0]        r_Index, w_Index;
  logic [DATA_BITS-1:0] r_Shift, w_Shift;
  logic [DATA_BITS-1:0] r_Byte,  w_Byte;
  logic                 r_DV,     w_DV;
  logic                 r_Active, w_Active;
  logic                 r_FErr,   w_FErr;
  logic                 w_Tick;
`ifdef UART_RX_PARITY_EN
  logic                 r_PErr,   w_PErr;
  logic                 r_Par_Bad, w_Par_Bad;
`endif

  uart_rx_sync u_sync (
    .i_Clock (i_Clock),
    .i_Rst_L (i_Rst_L),
    .i_Async (i_RX_Serial),
    .o_Sync  (r_RX)
  );

  assign w_Tick = (r_Count == LAST);

  // o_RX_DV and the error outputs are strobes with no backpressure: the
  // consumer must take o_RX_Byte on the DV cycle or read it later (held).
  always_comb begin
    w_State  = r_State;
    w_Count  = r_Count;
    w_Index  = r_Index;
    w_Shift  = r_Shift;
    w_Byte   = r_Byte;
    w_DV     = 1'b0;
    w_FErr   = 1'b0;
    w_Active = r_Active;
`ifdef UART_RX_PARITY_EN
    w_PErr    = 1'b0;
    w_Par_Bad = r_Par_Bad;
`endif
    case (r_State)
      S_IDLE: begin
        w_Count = '0;
        w_Index = '0;
`ifdef UART_RX_PARITY_EN
        w_Par_Bad = 1'b0;
`endif
        if (r_RX != IDLE_LEVEL) begin
          w_State  = S_START;
          w_Active = 1'b1;
        end
      end
      S_START: begin
        if (r_Count == HALF) begin
          w_Count = '0;
          if (r_RX != IDLE_LEVEL) begin
            w_State = S_DATA;
          end else begin
            w_State  = S_IDLE;
            w_Active = 1'b0;
          end
        end else begin
          w_Count = r_Count + CW'(1);
        end
      end
      S_DATA: begin
        if (w_Tick) begin
          w_Count = '0;
          w_Shift = {r_RX, r_Shift[DATA_BITS-1:1]};
          w_Index = r_Index + IW'(1);
          if (r_Index == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            w_State = S_PARITY;
`else
            w_State = S_STOP;
`endif
          end
        end else begin
          w_Count = r_Count + CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_Tick) begin
          w_Count   = '0;
          w_Par_Bad = r_RX ^ (^r_Shift);
          w_State   = S_STOP;
        end else begin
          w_Count = r_Count + CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (w_Tick) begin
          w_Count = '0;
          if (r_RX == IDLE_LEVEL) begin
            w_State = S_CLEANUP;
`ifdef UART_RX_PARITY_EN
            if (r_Par_Bad) begin
              w_PErr = 1'b1;
            end else begin
              w_Byte = r_Shift;
              w_DV   = 1'b1;
            end
`else
            w_Byte = r_Shift;
            w_DV   = 1'b1;
`endif
          end else begin
            // Stop bit low: wait out any break before hunting for a start.
            w_FErr   = 1'b1;
            w_State  = S_WAIT_IDLE;
            w_Active = 1'b0;
          end
        end else begin
          w_Count = r_Count + CW'(1);
        end
      end
      S_CLEANUP: begin
        w_Active = 1'b0;
        w_State  = S_IDLE;
      end
      S_WAIT_IDLE: begin
        w_Active = 1'b0;
        if (r_RX == IDLE_LEVEL) w_State = S_IDLE;
      end
      default: begin
        w_Active = 1'b0;
        w_State  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_State  <= S_IDLE;
      r_Count  <= '0;
      r_Index  <= '0;
      r_Shift  <= '0;
      r_Byte   <= '0;
      r_DV     <= 1'b0;
      r_Active <= 1'b0;
      r_FErr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_PErr    <= 1'b0;
      r_Par_Bad <= 1'b0;
`endif
    end else begin
      r_State  <= w_State;
      r_Count  <= w_Count;
      r_Index  <= w_Index;
      r_Shift  <= w_Shift;
      r_Byte   <= w_Byte;
      r_DV     <= w_DV;
      r_Active <= w_Active;
      r_FErr   <= w_FErr;
`ifdef UART_RX_PARITY_EN
      r_PErr    <= w_PErr;
      r_Par_Bad <= w_Par_Bad;
`endif
    end
  end

  assign o_RX_DV        = r_DV;
  assign o_RX_Byte      = r_Byte;
  assign o_RX_Active    = r_Active;
  assign o_RX_Frame_Err = r_FErr;
  assign o_RX_State     = r_State;
`ifdef UART_RX_PARITY_EN
  assign o_RX_Parity_Err = r_PErr;
`else
  assign o_RX_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: table of frames, hand-written corner sequences, random frames vs a frame-level model.
module tb_uart_rx_core;
  import uart_pkg::*;

  localparam int CPB = 217;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CLKS = FRAME_BITS * CPB;
  // Mid-stop sample plus synchronizer and output register delay.
  localparam int DV_LAT     = ((2 * FRAME_BITS - 1) * CPB) / 2 + 3;

  logic        i_Clock = 1'b0;
  logic        i_Rst_L = 1'b0;
  logic        i_RX_Serial = 1'b1;
  logic        o_RX_DV;
  logic [7:0]  o_RX_Byte;
  logic        o_RX_Active;
  logic        o_RX_Frame_Err;
  logic        o_RX_Parity_Err;
  uart_state_e o_RX_State;

  uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock         (i_Clock),
    .i_Rst_L         (i_Rst_L),
    .i_RX_Serial     (i_RX_Serial),
    .o_RX_DV         (o_RX_DV),
    .o_RX_Byte       (o_RX_Byte),
    .o_RX_Active     (o_RX_Active),
    .o_RX_Frame_Err  (o_RX_Frame_Err),
    .o_RX_Parity_Err (o_RX_Parity_Err),
    .o_RX_State      (o_RX_State)
  );

  // ---------------- clock / reset ----------------
  always #5 i_Clock = ~i_Clock;

  int cyc = 0;
  always @(posedge i_Clock) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded 100000 cycles");
    $fatal(1, "timeout");
  end

  // ---------------- monitor ----------------
  int         dv_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
  int         overlap_cnt = 0, long_cnt = 0;
  int         last_dv_cyc = 0;
  logic [7:0] last_dv_byte = 8'h00;
  logic       prev_strobe = 1'b0;

  always @(negedge i_Clock) begin
    int n;
    n = int'(o_RX_DV) + int'(o_RX_Frame_Err) + int'(o_RX_Parity_Err);
    if (n > 1) overlap_cnt++;
    if (n > 0 && prev_strobe) long_cnt++;
    prev_strobe = (n > 0);
    if (o_RX_DV) begin
      dv_cnt++;
      last_dv_cyc  = cyc;
      last_dv_byte = o_RX_Byte;
    end
    if (o_RX_Frame_Err)  ferr_cnt++;
    if (o_RX_Parity_Err) perr_cnt++;
  end

  // ---------------- scoreboard ----------------
  int         total = 0, bad = 0;
  int         dv_base, ferr_base, perr_base;
  int         start_cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic snap();
    dv_base   = dv_cnt;
    ferr_base = ferr_cnt;
    perr_base = perr_cnt;
  endtask

  task automatic check_frame(input string name, input int edv, input int ef, input int ep,
                             input logic [7:0] ebyte);
    @(negedge i_Clock);
    chk({name, " dv_count"}, dv_cnt - dv_base, edv);
    chk({name, " ferr_count"}, ferr_cnt - ferr_base, ef);
    chk({name, " perr_count"}, perr_cnt - perr_base, ep);
    chk({name, " held_byte"}, int'(o_RX_Byte), int'(ebyte));
    if (edv == 1 && exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      chk({name, " dv_byte"}, int'(last_dv_byte), int'(e));
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_bit(input logic b, input int clks);
    @(posedge i_Clock);
    #1;
    i_RX_Serial = b;
    repeat (clks - 1) @(posedge i_Clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
    @(posedge i_Clock);
    #1;
    i_RX_Serial = 1'b0;
    start_cyc = cyc;
    repeat (CPB - 1) @(posedge i_Clock);
    for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip, CPB);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    drive_bit(stop_b, CPB);
  endtask

  task automatic idle(input int n);
    if (n > 0) drive_bit(1'b1, n);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] data;
    logic       stop_b;
    logic       par_flip;
    int         gap;
    int         exp_dv;
    int         exp_ferr;
    int         exp_perr;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int d1;
    int act_cycles;
    vecs.push_back('{8'h3F, 1'b1, 1'b0, 20, 1, 0, 0, 8'h3F});
    vecs.push_back('{8'hA5, 1'b1, 1'b0, 20, 1, 0, 0, 8'hA5});
    vecs.push_back('{8'h12, 1'b0, 1'b0, 40, 0, 1, 0, 8'hA5});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 0,  1, 0, 0, 8'h00});
    vecs.push_back('{8'hFF, 1'b1, 1'b0, 0,  1, 0, 0, 8'hFF});
    vecs.push_back('{8'h80, 1'b1, 1'b0, 10, 1, 0, 0, 8'h80});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'h3F, 1'b1, 1'b0, 20, 1, 0, 0, 8'h3F});
    vecs.push_back('{8'h3F, 1'b1, 1'b1, 20, 0, 0, 1, 8'h3F});
`endif

    // Reset state
    repeat (5) @(posedge i_Clock);
    @(negedge i_Clock);
    chk("reset dv", int'(o_RX_DV), 0);
    chk("reset byte", int'(o_RX_Byte), 0);
    chk("reset active", int'(o_RX_Active), 0);
    chk("reset ferr", int'(o_RX_Frame_Err), 0);
    chk("reset perr", int'(o_RX_Parity_Err), 0);
    chk("reset state", int'(o_RX_State), int'(S_IDLE));
    @(posedge i_Clock);
    #1 i_Rst_L = 1'b1;
    idle(20);

    // Table-driven frames
    foreach (vecs[k]) begin
      snap();
      if (vecs[k].exp_dv == 1) exp_q.push_back(vecs[k].data);
      send_frame(vecs[k].data, vecs[k].stop_b, vecs[k].par_flip);
      check_frame($sformatf("vec%0d", k), vecs[k].exp_dv, vecs[k].exp_ferr,
                  vecs[k].exp_perr, vecs[k].exp_byte);
      idle(vecs[k].gap);
    end
    last_good = 8'h80;
`ifdef UART_RX_PARITY_EN
    last_good = 8'h3F;
`endif

    // Latency from start-bit fall to DV
    snap();
    exp_q.push_back(8'h3F);
    send_frame(8'h3F, 1'b1, 1'b0);
    last_good = 8'h3F;
    check_frame("latency 3F", 1, 0, 0, 8'h3F);
    chk_range("dv latency", last_dv_cyc - start_cyc, DV_LAT - 4, DV_LAT + 4);
    idle(20);

    // Back-to-back frames with zero idle
    snap();
    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b1, 1'b0);
    check_frame("b2b 00", 1, 0, 0, 8'h00);
    d1 = last_dv_cyc;
    snap();
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1, 1'b0);
    last_good = 8'hFF;
    check_frame("b2b FF", 1, 0, 0, 8'hFF);
    chk_range("b2b dv spacing", last_dv_cyc - d1, FRAME_CLKS - 2, FRAME_CLKS + 2);
    idle(20);

    // Glitch: line low 50 clocks
    snap();
    act_cycles = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge i_Clock);
      #1;
      if (i == 0)  i_RX_Serial = 1'b0;
      if (i == 50) i_RX_Serial = 1'b1;
      @(negedge i_Clock);
      if (o_RX_Active) act_cycles++;
    end
    chk_range("glitch active width", act_cycles, 1, (CPB - 1) / 2 + 1);
    chk("glitch state", int'(o_RX_State), int'(S_IDLE));
    chk("glitch pulses", (dv_cnt - dv_base) + (ferr_cnt - ferr_base) + (perr_cnt - perr_base), 0);

    // Good frame, then framing error followed by a break
    snap();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    last_good = 8'hA5;
    check_frame("pre-ferr A5", 1, 0, 0, 8'hA5);
    idle(15);
    snap();
    send_frame(8'h12, 1'b0, 1'b0);
    check_frame("ferr 12", 0, 1, 0, 8'hA5);
    chk("ferr state", int'(o_RX_State), int'(S_WAIT_IDLE));
    act_cycles = 0;
    for (int i = 0; i < 3 * CPB; i++) begin
      @(negedge i_Clock);
      if (o_RX_Active) act_cycles++;
    end
    chk("break active", act_cycles, 0);
    chk("break state", int'(o_RX_State), int'(S_WAIT_IDLE));
    idle(10);
    @(negedge i_Clock);
    chk("after break state", int'(o_RX_State), int'(S_IDLE));
    snap();
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0);
    last_good = 8'h3C;
    check_frame("post-break 3C", 1, 0, 0, 8'h3C);
    idle(20);

    // Reset during data bit 4 of 8'h55
    snap();
    @(posedge i_Clock);
    #1 i_RX_Serial = 1'b0;
    repeat (CPB - 1) @(posedge i_Clock);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h55 >> i), CPB);
    @(posedge i_Clock);
    #1 i_RX_Serial = 1'b1;
    repeat (CPB / 2) @(posedge i_Clock);
    #2;
    chk("pre-reset active", int'(o_RX_Active), 1);
    i_Rst_L = 1'b0;
    #1;
    chk("midreset dv", int'(o_RX_DV), 0);
    chk("midreset byte", int'(o_RX_Byte), 0);
    chk("midreset active", int'(o_RX_Active), 0);
    chk("midreset state", int'(o_RX_State), int'(S_IDLE));
    chk("midreset errs", int'(o_RX_Frame_Err) + int'(o_RX_Parity_Err), 0);
    repeat (5) @(posedge i_Clock);
    #1 i_Rst_L = 1'b1;
    last_good = 8'h00;
    idle(30);
    chk("midreset pulses", (dv_cnt - dv_base) + (ferr_cnt - ferr_base) + (perr_cnt - perr_base), 0);
    snap();
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b0);
    last_good = 8'h55;
    check_frame("post-reset 55", 1, 0, 0, 8'h55);
    idle(20);

    // Random frames against the frame-level model
    for (int k = 0; k < 8; k++) begin
      logic [7:0] d;
      logic       stop_b, pf;
      int         gap, edv, ef, ep;
      d      = 8'($urandom_range(0, 255));
      stop_b = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
      pf = ($urandom_range(0, 3) == 0);
`else
      pf = 1'b0;
`endif
      gap = stop_b ? $urandom_range(0, 30) : $urandom_range(8, 40);
      edv = 0; ef = 0; ep = 0;
      if (!stop_b) ef = 1;
      else if (pf) ep = 1;
      else begin
        edv = 1;
        exp_q.push_back(d);
        last_good = d;
      end
      snap();
      send_frame(d, stop_b, pf);
      check_frame($sformatf("rand%0d", k), edv, ef, ep, last_good);
      idle(gap);
    end

    chk("strobe overlap", overlap_cnt, 0);
    chk("strobe width", long_cnt, 0);
    chk("leftover expected", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
